tdm_demux: RTL



---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_demux_if.sv | 32 +++
 rtl/tdm_shift_in.sv | 18 +
 rtl/tdm_demux.sv | 129 ++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM receive (tdm_demux) and transmit (tdm_mux) paths.
package tdm_pkg;

  localparam int TDM_CHANNELS = 4;
  localparam int TDM_WIDTH    = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE = ST_IDLE,
    S_RECV = ST_RECV
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux_if.sv
// Bus between the serial link side and the demultiplexer.
// Handshake: a beat is transferred on every rising clock edge where enable=1;
// there is no back-pressure. sync/din are meaningful only on such beats.
// ch_valid[c] and frame_done are single-cycle pulses qualifying ch_data and
// the frame boundary; ch_data and sync_err are level outputs.
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int CHANNELS = TDM_CHANNELS,
  parameter int WIDTH    = TDM_WIDTH
) ();

  logic                      enable;
  logic                      sync;
  logic                      din;
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]       ch_valid;
  logic                      frame_done;
  logic                      sync_err;
  tdm_state_e                fsm_state;

  modport master (
    output enable, sync, din,
    input  ch_data, ch_valid, frame_done, sync_err, fsm_state
  );

  modport slave (
    input  enable, sync, din,
    output ch_data, ch_valid, frame_done, sync_err, fsm_state
  );

endinterface

// File: rtl/tdm_shift_in.sv
// Serial-in/parallel-out shift register, MSB arrives first.
module tdm_shift_in #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Shift one bit in at the LSB on each load.
  always_ff @(posedge clock) begin
    if (!resetn) q <= '0;
    else if (load) q <= {q[WIDTH-2:0], din};
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: frames of CHANNELS slots x WIDTH bits, each slot latched
// into its own parallel output register.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int CHANNELS = TDM_CHANNELS,
  parameter int WIDTH    = TDM_WIDTH
) (
  input logic        clock,
  input logic        resetn,
  tdm_demux_if.slave bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(CHANNELS);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);

  tdm_state_e                state_q, state_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic                      err_q, err_d;
  logic                      shift_en, slot_wr, frame_end;
  logic [WIDTH-1:0]          shift_q;
  logic [WIDTH-1:0]          word;
  logic [CHANNELS*WIDTH-1:0] ch_data_q;
  logic [CHANNELS-1:0]       ch_valid_q;
  logic                      frame_done_q;

  tdm_shift_in #(.WIDTH(WIDTH)) u_shift (
    .clock (clock),
    .resetn(resetn),
    .load  (shift_en),
    .din   (bus.din),
    .q     (shift_q)
  );

  // The completed word includes the bit arriving on this beat.
  assign word = {shift_q[WIDTH-2:0], bus.din};

  // State, counter and sticky error registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
    end
  end

  // Next-state decode: a sync always restarts at channel 0 bit 1, even on
  // the beat that would otherwise complete the last slot.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    ch_d      = ch_q;
    err_d     = err_q;
    shift_en  = 1'b0;
    slot_wr   = 1'b0;
    frame_end = 1'b0;
    if (bus.enable) begin
      case (state_q)
        S_IDLE: begin
          if (bus.sync) begin
            shift_en = 1'b1;
            bit_d    = BW'(1);
            ch_d     = '0;
            state_d  = S_RECV;
          end
        end
        S_RECV: begin
          shift_en = 1'b1;
          if (bus.sync) begin
            err_d = 1'b1;
            bit_d = BW'(1);
            ch_d  = '0;
          end else if (bit_q == BIT_LAST) begin
            slot_wr = 1'b1;
            bit_d   = '0;
            if (ch_q == CH_LAST) begin
              frame_end = 1'b1;
              ch_d      = '0;
              state_d   = S_IDLE;
            end else begin
              ch_d = ch_q + CW'(1);
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Slot registers: only the slot addressed by ch_q is written.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ch_data_q <= '0;
    end else if (slot_wr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_q == CW'(c)) ch_data_q[c*WIDTH +: WIDTH] <= word;
      end
    end
  end

  // Completion pulses, one cycle each.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ch_valid_q   <= slot_wr ? (CHANNELS'(1) << ch_q) : '0;
      frame_done_q <= frame_end;
    end
  end

  assign bus.ch_data    = ch_data_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = err_q;
  assign bus.fsm_state  = state_q;

endmodule
